tsip_rx_parser: RTL and testbench

TSIP_RX_PARSER -- requirements
Module: tsip_rx_parser

---
 rtl/tsip_rx_parser.sv | 240 ++++++++++++++++++++++++
 tb/tb_tsip_rx_parser.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tsip_rx_parser.sv
// TSIP packet receiver: UART 8N1 deframer plus DLE/ETX unstuffing into a payload buffer.
// Optional sub-ID filter enabled by defining TSIP_SUBID_FILTER_EN.
module tsip_rx_parser #(
  parameter int unsigned CLKS_PER_BIT = 1042,
  parameter int unsigned MAX_BYTES    = 11,
  parameter logic [7:0]  PKT_ID       = 8'h8F,
  parameter logic [7:0]  SUB_ID       = 8'hAB
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_rx,
  output logic                   o_packet_dv,
  output logic [8*MAX_BYTES-1:0] o_packet_data,
  output logic [5:0]             o_packet_len,
  output logic                   o_err
);

  localparam int unsigned DATA_W   = 8 * MAX_BYTES;
  localparam int unsigned CNT_W    = $clog2(CLKS_PER_BIT + 1);
  localparam int unsigned HALF_BIT = (CLKS_PER_BIT / 2 > 0) ? CLKS_PER_BIT / 2 : 1;

  localparam logic [7:0] DLE = 8'h10;
  localparam logic [7:0] ETX = 8'h03;

  localparam logic [1:0] U_IDLE  = 2'd0;
  localparam logic [1:0] U_START = 2'd1;
  localparam logic [1:0] U_DATA  = 2'd2;
  localparam logic [1:0] U_STOP  = 2'd3;

  localparam logic [1:0] DF_IDLE     = 2'd0;
  localparam logic [1:0] DF_GET_ID   = 2'd1;
  localparam logic [1:0] DF_DATA     = 2'd2;
  localparam logic [1:0] DF_DATA_DLE = 2'd3;

  logic             rx_meta_q, rx_meta_d;
  logic             rx_sync_q, rx_sync_d;
  logic             rx_prev_q, rx_prev_d;
  logic [1:0]       u_state_q, u_state_d;
  logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             byte_stb_q, byte_stb_d;
  logic             frame_err_q, frame_err_d;

  logic [1:0]        df_state_q, df_state_d;
  logic [5:0]        count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              discard_q, discard_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic              dv_q, dv_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [5:0]        len_q, len_d;

  logic store_c, open_c, close_c, filter_ok_c;

  // UART receiver: synchronizer, falling-edge start detect, mid-bit sampling
  always_comb begin
    rx_meta_d   = i_rx;
    rx_sync_d   = rx_meta_q;
    rx_prev_d   = rx_sync_q;
    u_state_d   = u_state_q;
    clk_cnt_d   = clk_cnt_q;
    bit_idx_d   = bit_idx_q;
    shreg_d     = shreg_q;
    byte_stb_d  = 1'b0;
    frame_err_d = 1'b0;
    case (u_state_q)
      U_IDLE: begin
        if (!rx_sync_q && rx_prev_q) begin
          u_state_d = U_START;
          clk_cnt_d = '0;
        end
      end
      U_START: begin
        if (clk_cnt_q == CNT_W'(HALF_BIT - 1)) begin
          clk_cnt_d = '0;
          bit_idx_d = '0;
          u_state_d = rx_sync_q ? U_IDLE : U_DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      U_DATA: begin
        if (clk_cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
          clk_cnt_d = '0;
          shreg_d   = {rx_sync_q, shreg_q[7:1]};
          if (bit_idx_q == 3'd7) u_state_d = U_STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      U_STOP: begin
        if (clk_cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
          clk_cnt_d   = '0;
          byte_stb_d  = rx_sync_q;
          frame_err_d = !rx_sync_q;
          u_state_d   = U_IDLE;
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      default: u_state_d = U_IDLE;
    endcase
  end

`ifdef TSIP_SUBID_FILTER_EN
  assign filter_ok_c = (count_q != 6'd0) && (buf_q[7:0] == SUB_ID);
`else
  logic unused_sub_id;
  assign unused_sub_id = ^SUB_ID;
  assign filter_ok_c   = 1'b1;
`endif

  // Deframer: classify each received byte, then apply open/store/close actions
  always_comb begin
    df_state_d = df_state_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    discard_d  = discard_q;
    buf_d      = buf_q;
    dv_d       = 1'b0;
    err_d      = 1'b0;
    data_d     = data_q;
    len_d      = len_q;
    store_c    = 1'b0;
    open_c     = 1'b0;
    close_c    = 1'b0;
    if (frame_err_q) begin
      err_d      = 1'b1;
      df_state_d = DF_IDLE;
    end else if (byte_stb_q) begin
      case (df_state_q)
        DF_IDLE: if (shreg_q == DLE) df_state_d = DF_GET_ID;
        DF_GET_ID: begin
          if (shreg_q == DLE || shreg_q == ETX) df_state_d = DF_IDLE;
          else                                  open_c     = 1'b1;
        end
        DF_DATA: begin
          if (shreg_q == DLE) df_state_d = DF_DATA_DLE;
          else                store_c    = 1'b1;
        end
        DF_DATA_DLE: begin
          if (shreg_q == DLE) begin
            store_c = 1'b1;
          end else if (shreg_q == ETX) begin
            close_c    = 1'b1;
            df_state_d = DF_IDLE;
          end else begin
            // Unexpected byte after DLE: the DLE starts a new frame and this byte is its ID
            err_d  = !discard_q;
            open_c = 1'b1;
          end
        end
        default: df_state_d = DF_IDLE;
      endcase
    end

    if (open_c) begin
      df_state_d = DF_DATA;
      count_d    = '0;
      ovf_d      = 1'b0;
      buf_d      = '0;
      discard_d  = (shreg_q != PKT_ID);
    end

    if (store_c) begin
      df_state_d = DF_DATA;
      if (!discard_q) begin
        if (count_q == 6'(MAX_BYTES)) begin
          ovf_d = 1'b1;
        end else begin
          for (int k = 0; k < MAX_BYTES; k++) begin
            if (count_q == 6'(k)) buf_d[8*k +: 8] = shreg_q;
          end
          count_d = count_q + 6'd1;
        end
      end
    end

    if (close_c && !discard_q) begin
      if (ovf_q) begin
        err_d = 1'b1;
      end else if (filter_ok_c) begin
        dv_d   = 1'b1;
        data_d = buf_q;
        len_d  = count_q;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      rx_prev_q   <= 1'b1;
      u_state_q   <= U_IDLE;
      clk_cnt_q   <= '0;
      bit_idx_q   <= '0;
      shreg_q     <= '0;
      byte_stb_q  <= 1'b0;
      frame_err_q <= 1'b0;
      df_state_q  <= DF_IDLE;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      discard_q   <= 1'b0;
      buf_q       <= '0;
      dv_q        <= 1'b0;
      err_q       <= 1'b0;
      data_q      <= '0;
      len_q       <= '0;
    end else begin
      rx_meta_q   <= rx_meta_d;
      rx_sync_q   <= rx_sync_d;
      rx_prev_q   <= rx_prev_d;
      u_state_q   <= u_state_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shreg_q     <= shreg_d;
      byte_stb_q  <= byte_stb_d;
      frame_err_q <= frame_err_d;
      df_state_q  <= df_state_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      discard_q   <= discard_d;
      buf_q       <= buf_d;
      dv_q        <= dv_d;
      err_q       <= err_d;
      data_q      <= data_d;
      len_q       <= len_d;
    end
  end

  assign o_packet_dv   = dv_q;
  assign o_err         = err_q;
  assign o_packet_data = data_q;
  assign o_packet_len  = len_q;

endmodule

// File: tb/tb_tsip_rx_parser.sv
// Scoreboard bench for tsip_rx_parser: directed frames plus randomized byte streams
// checked against a queue-based TSIP packet model.
module tb_tsip_rx_parser;

  localparam int unsigned CPB  = 16;
  localparam int unsigned MAXB = 4;
  localparam int unsigned DW   = 8 * MAXB;

  logic          clk;
  logic          rst;
  logic          rx;
  logic          dv;
  logic [DW-1:0] data;
  logic [5:0]    len;
  logic          err;

  tsip_rx_parser #(.CLKS_PER_BIT(CPB), .MAX_BYTES(MAXB), .PKT_ID(8'h8F), .SUB_ID(8'hAB)) dut (
    .i_clk(clk), .i_rst(rst), .i_rx(rx),
    .o_packet_dv(dv), .o_packet_data(data), .o_packet_len(len), .o_err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          is_err;
    logic [5:0]    len;
    logic [DW-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model: where we are in a frame, plus the unstuffed payload so far
  int            m_mode;   // 0 hunting for DLE, 1 expecting ID, 2 in body
  bit            m_esc;
  bit            m_keep;
  logic [7:0]    m_pl[$];
  logic [5:0]    m_last_len;
  logic [DW-1:0] m_last_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push_err();
    exp_t e;
    e.is_err = 1'b1;
    e.len    = '0;
    e.data   = '0;
    exp_q.push_back(e);
  endtask

  task automatic model_reset();
    m_mode      = 0;
    m_esc       = 1'b0;
    m_keep      = 1'b0;
    m_pl.delete();
    m_last_len  = '0;
    m_last_data = '0;
  endtask

  task automatic model_open(input logic [7:0] id);
    m_mode = 2;
    m_esc  = 1'b0;
    m_keep = (id == 8'h8F);
    m_pl.delete();
  endtask

  task automatic model_close();
    exp_t e;
    bit   drop;
    if (!m_keep) return;
    if (m_pl.size() > MAXB) begin
      push_err();
      return;
    end
    drop = 1'b0;
`ifdef TSIP_SUBID_FILTER_EN
    drop = (m_pl.size() == 0) || (m_pl[0] != 8'hAB);
`endif
    if (drop) return;
    e.is_err = 1'b0;
    e.len    = 6'(m_pl.size());
    e.data   = '0;
    for (int i = 0; i < m_pl.size(); i++) e.data[8*i +: 8] = m_pl[i];
    m_last_len  = e.len;
    m_last_data = e.data;
    exp_q.push_back(e);
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (m_mode == 0) begin
      if (b == 8'h10) m_mode = 1;
    end else if (m_mode == 1) begin
      if (b == 8'h10 || b == 8'h03) m_mode = 0;
      else model_open(b);
    end else if (!m_esc) begin
      if (b == 8'h10) m_esc = 1'b1;
      else m_pl.push_back(b);
    end else begin
      m_esc = 1'b0;
      if (b == 8'h10) m_pl.push_back(b);
      else if (b == 8'h03) begin
        model_close();
        m_mode = 0;
      end else begin
        if (m_keep) push_err();
        model_open(b);
      end
    end
  endtask

  task automatic bit_time(input logic v);
    rx = v;
    repeat (CPB) @(negedge clk);
  endtask

  // Expectation is queued before the byte goes out because the DUT reacts inside the stop bit
  task automatic send(input logic [7:0] b, input bit bad_stop);
    if (bad_stop) begin
      push_err();
      m_mode = 0;
      m_esc  = 1'b0;
    end else begin
      model_byte(b);
    end
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(b[i]);
    bit_time(!bad_stop);
    if (bad_stop) repeat (2) bit_time(1'b1);
  endtask

  task automatic send_list(input logic [7:0] bl[$]);
    foreach (bl[i]) send(bl[i], 1'b0);
  endtask

  task automatic idle_and_check_held(input string tag);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    chk({tag, "_held_len"}, 64'(len), 64'(m_last_len));
    chk({tag, "_held_data"}, 64'(data), 64'(m_last_data));
  endtask

  // Monitor: every output pulse must match the head of the scoreboard queue
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && (dv || err)) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pulse dv=%0b err=%0b len=%0d data=%0h", dv, err, len, data);
        end else begin
          e = exp_q.pop_front();
          chk("pulse_err", 64'(err), 64'(e.is_err));
          chk("pulse_dv", 64'(dv), 64'(!e.is_err));
          if (!e.is_err) begin
            chk("pkt_len", 64'(len), 64'(e.len));
            chk("pkt_data", 64'(data), 64'(e.data));
          end
        end
      end
    end
  end

  initial begin
    logic [7:0] bl[$];
    int         wait_cnt;
    rst = 1'b1;
    rx  = 1'b1;
    model_reset();
    repeat (5) @(negedge clk);
    chk("rst_dv", 64'(dv), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_data", 64'(data), 64'd0);
    chk("rst_len", 64'(len), 64'd0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    bl = '{8'h10, 8'h8F, 8'hAB, 8'h01, 8'h02, 8'h10, 8'h03};
    send_list(bl);
    idle_and_check_held("basic");
    chk("basic_const_len", 64'(len), 64'd3);
    chk("basic_const_data", 64'(data), 64'h0002_01AB);

    bl = '{8'h10, 8'h8F, 8'h10, 8'h10, 8'h55, 8'h10, 8'h03};
    send_list(bl);
    idle_and_check_held("stuffed");

    bl = '{8'h10, 8'h8F, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h10, 8'h03};
    send_list(bl);
    idle_and_check_held("overflow");

    bl = '{8'h10, 8'h8F, 8'hAB, 8'h0A, 8'h0B, 8'h0C, 8'h10, 8'h03};
    send_list(bl);
    idle_and_check_held("full");

    bl = '{8'h10, 8'h47, 8'h01, 8'h10, 8'h03, 8'h10, 8'h8F, 8'h10, 8'h41, 8'h01, 8'h10, 8'h03};
    send_list(bl);
    idle_and_check_held("foreign_id");

    bl = '{8'h10, 8'h8F, 8'hAB, 8'h10, 8'h8F, 8'hAB, 8'h10, 8'h03};
    send_list(bl);
    idle_and_check_held("resync");

    bl = '{8'h10, 8'h8F, 8'h10, 8'h03};
    send_list(bl);
    idle_and_check_held("empty");

    send(8'h10, 1'b0);
    send(8'h8F, 1'b0);
    send(8'h22, 1'b1);
    bl = '{8'h10, 8'h8F, 8'hAA, 8'h10, 8'h03};
    send_list(bl);
    idle_and_check_held("badstop");

    bl = '{8'h10, 8'h8F, 8'hAC, 8'h10, 8'h03};
    send_list(bl);
    idle_and_check_held("subid");

    // Reset in the middle of the third payload byte
    bl = '{8'h10, 8'h8F, 8'hAB, 8'h02};
    send_list(bl);
    bit_time(1'b0);
    bit_time(1'b1);
    bit_time(1'b1);
    rst = 1'b1;
    rx  = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    chk("midrst_dv", 64'(dv), 64'd0);
    chk("midrst_err", 64'(err), 64'd0);
    chk("midrst_data", 64'(data), 64'd0);
    chk("midrst_len", 64'(len), 64'd0);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    bl = '{8'h10, 8'h8F, 8'hAB, 8'h33, 8'h10, 8'h03};
    send_list(bl);
    idle_and_check_held("postrst");

    for (int f = 0; f < 40; f++) begin
      int unsigned n;
      logic [7:0]  b;
      bl.delete();
      if ($urandom_range(0, 3) == 0) bl.push_back(8'($urandom_range(0, 255)));
      bl.push_back(8'h10);
      case ($urandom_range(0, 9))
        0:       bl.push_back(8'h47);
        1:       bl.push_back(8'($urandom_range(0, 255)));
        default: bl.push_back(8'h8F);
      endcase
      n = $urandom_range(0, 6);
      for (int i = 0; i < n; i++) begin
        case ($urandom_range(0, 5))
          0:       b = 8'h10;
          1:       b = 8'h03;
          2, 3:    b = 8'hAB;
          default: b = 8'($urandom_range(0, 255));
        endcase
        bl.push_back(b);
        if (b == 8'h10) bl.push_back(8'h10);
      end
      bl.push_back(8'h10);
      bl.push_back(($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'h03);
      foreach (bl[i]) send(bl[i], $urandom_range(0, 49) == 0);
      idle_and_check_held("rand");
    end

    wait_cnt = 0;
    while (exp_q.size() != 0 && wait_cnt < 400) begin
      @(negedge clk);
      wait_cnt++;
    end
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
